// File: rtl/cmos_dvp_cap_pkg.sv
// Shared definitions for the DVP capture block: pixel format codes, FSM states
// and the bytes-per-pixel lookup.
package cmos_dvp_cap_pkg;

  typedef enum logic [1:0] {
    FMT_RGB565 = 2'd0,
    FMT_RGB888 = 2'd1,
    FMT_GRAY8  = 2'd2,
    FMT_RSVD   = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_SKIP    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_e;

  // The reserved code falls through to GRAY8 sizing.
  function automatic logic [1:0] fmt_bpp(input logic [1:0] fmt);
    case (fmt)
      FMT_RGB565: return 2'd2;
      FMT_RGB888: return 2'd3;
      default:    return 2'd1;
    endcase
  endfunction

endpackage

// File: rtl/cmos_dvp_cap_if.sv
// Sensor byte bus in, aligned 24-bit video timing out, bundled as one interface.
interface cmos_dvp_cap_if;
  logic        cmos_vsync_i;
  logic        cmos_href_i;
  logic [7:0]  cmos_data_i;
  logic        vs_o;
  logic        hs_o;
  logic        de_o;
  logic [23:0] rgb_o;

  modport master (
    output cmos_vsync_i, cmos_href_i, cmos_data_i,
    input  vs_o, hs_o, de_o, rgb_o
  );

  modport slave (
    input  cmos_vsync_i, cmos_href_i, cmos_data_i,
    output vs_o, hs_o, de_o, rgb_o
  );
endinterface

// File: rtl/cmos_dvp_cap_pix_pack.sv
// Byte phase counter and format expansion: turns the registered sensor byte
// stream into complete 24-bit pixels and flags lines that end mid-pixel.
module cmos_pix_pack
  import cmos_dvp_cap_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  fmt,
  input  logic        href,
  input  logic        href_prev,
  input  logic [7:0]  data,
  output logic        pix_valid,
  output logic [23:0] pix_rgb,
  output logic        line_err
);

  logic [1:0] phase_reg, phase_next, eff_phase, last_phase;
  logic [7:0] b0_reg, b1_reg;
  logic       href_rise, href_fall;

  always_comb begin
    href_rise  = href & ~href_prev;
    href_fall  = ~href & href_prev;
    // A line start forces phase 0 for the byte arriving with it.
    eff_phase  = href_rise ? 2'd0 : phase_reg;
    last_phase = fmt_bpp(fmt) - 2'd1;
    pix_valid  = href && (eff_phase == last_phase);
    line_err   = href_fall && (phase_reg != 2'd0);

    phase_next = 2'd0;
    if (href && !pix_valid)
      phase_next = eff_phase + 2'd1;

    pix_rgb = '0;
    case (fmt)
      FMT_RGB565: pix_rgb = {b0_reg[7:3], b0_reg[7:5],
                             b0_reg[2:0], data[7:5], b0_reg[2:1],
                             data[4:0], data[4:2]};
      FMT_RGB888: pix_rgb = {b0_reg, b1_reg, data};
      default:    pix_rgb = {data, data, data};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_reg <= 2'd0;
      b0_reg    <= 8'd0;
      b1_reg    <= 8'd0;
    end else begin
      phase_reg <= phase_next;
      if (href && eff_phase == 2'd0) b0_reg <= data;
      if (href && eff_phase == 2'd1) b1_reg <= data;
    end
  end

endmodule

// File: rtl/cmos_dvp_cap.sv
// DVP capture top: input register stage, frame-skip FSM, format latch and the
// aligned output register. Define CMOS_CAP_STATS_EN to export line/frame counts.
module cmos_dvp_cap
  import cmos_dvp_cap_pkg::*;
#(
  parameter int SKIP_FRAMES = 10,
  parameter int VS_POL      = 1,
  parameter int CNT_W       = 12
) (
  input  logic             cmos_pclk_i,
  input  logic             rst_i,
  cmos_dvp_cap_if.slave    bus,
  input  logic [1:0]       fmt_i,
  output logic             frame_start_o,
  output logic             err_o
`ifdef CMOS_CAP_STATS_EN
  ,
  output logic [CNT_W-1:0] line_px_o,
  output logic [CNT_W-1:0] frame_lines_o
`endif
);

  localparam int SKIP_W = 16;

  state_e            state_reg, state_next;
  logic [SKIP_W-1:0] skip_cnt_reg, skip_cnt_next;
  logic [1:0]        fmt_q_reg;
  logic              vs_act_reg, vs_act_prev_reg, href_reg, href_prev_reg;
  logic [7:0]        data_reg;
  logic              fs_edge, fmt_load, out_en;
  logic              pix_valid, line_err;
  logic [23:0]       pix_rgb;

  assign fs_edge = vs_act_prev_reg & ~vs_act_reg;
  assign out_en  = (state_reg == ST_ACTIVE);

  always_comb begin
    state_next    = state_reg;
    skip_cnt_next = skip_cnt_reg;
    fmt_load      = 1'b0;
    case (state_reg)
      ST_SKIP: begin
        if (SKIP_FRAMES == 0) begin
          state_next = ST_WAIT_VS;
        end else if (fs_edge) begin
          if (skip_cnt_reg == SKIP_W'(SKIP_FRAMES - 1)) begin
            state_next    = ST_WAIT_VS;
            skip_cnt_next = '0;
          end else begin
            skip_cnt_next = skip_cnt_reg + 1'b1;
          end
        end
      end
      ST_WAIT_VS: begin
        if (fs_edge) begin
          state_next = ST_ACTIVE;
          fmt_load   = 1'b1;
        end
      end
      ST_ACTIVE: fmt_load = fs_edge;
      default:   state_next = ST_SKIP;
    endcase
  end

  always_ff @(posedge cmos_pclk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg       <= ST_SKIP;
      skip_cnt_reg    <= '0;
      fmt_q_reg       <= FMT_RGB565;
      vs_act_reg      <= 1'b0;
      vs_act_prev_reg <= 1'b0;
      href_reg        <= 1'b0;
      href_prev_reg   <= 1'b0;
      data_reg        <= 8'd0;
    end else begin
      state_reg       <= state_next;
      skip_cnt_reg    <= skip_cnt_next;
      vs_act_reg      <= (bus.cmos_vsync_i == 1'(VS_POL));
      vs_act_prev_reg <= vs_act_reg;
      href_reg        <= bus.cmos_href_i;
      href_prev_reg   <= href_reg;
      data_reg        <= bus.cmos_data_i;
      if (fmt_load) fmt_q_reg <= fmt_i;
    end
  end

  cmos_pix_pack u_pix_pack (
    .clk       (cmos_pclk_i),
    .rst       (rst_i),
    .fmt       (fmt_q_reg),
    .href      (href_reg),
    .href_prev (href_prev_reg),
    .data      (data_reg),
    .pix_valid (pix_valid),
    .pix_rgb   (pix_rgb),
    .line_err  (line_err)
  );

  // Output stage: everything is gated to inactive until the first post-skip frame.
  always_ff @(posedge cmos_pclk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.vs_o      <= 1'b0;
      bus.hs_o      <= 1'b0;
      bus.de_o      <= 1'b0;
      bus.rgb_o     <= 24'd0;
      frame_start_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      bus.vs_o      <= out_en & vs_act_reg;
      bus.hs_o      <= out_en & href_reg;
      bus.de_o      <= out_en & pix_valid;
      if (out_en && pix_valid) bus.rgb_o <= pix_rgb;
      frame_start_o <= fmt_load;
      if (fmt_load)
        err_o <= 1'b0;
      else if (out_en && line_err)
        err_o <= 1'b1;
    end
  end

`ifdef CMOS_CAP_STATS_EN
  logic [CNT_W-1:0] px_cnt_reg, line_cnt_reg;

  always_ff @(posedge cmos_pclk_i or posedge rst_i) begin
    if (rst_i) begin
      px_cnt_reg    <= '0;
      line_cnt_reg  <= '0;
      line_px_o     <= '0;
      frame_lines_o <= '0;
    end else begin
      if (fmt_load) begin
        frame_lines_o <= line_cnt_reg;
        line_cnt_reg  <= '0;
        px_cnt_reg    <= '0;
      end else if (out_en) begin
        if (!href_reg && href_prev_reg) begin
          line_px_o  <= px_cnt_reg;
          px_cnt_reg <= '0;
          if (line_cnt_reg != '1) line_cnt_reg <= line_cnt_reg + 1'b1;
        end else if (pix_valid && px_cnt_reg != '1) begin
          px_cnt_reg <= px_cnt_reg + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cmos_dvp_cap.sv
// Directed bench for cmos_dvp_cap: frame skip, format expansion, latency,
// line errors, mid-frame format change and asynchronous reset.
module tb_cmos_dvp_cap;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fmt = 2'd0;
  logic       frame_start, err;
`ifdef CMOS_CAP_STATS_EN
  logic [11:0] line_px, frame_lines;
`endif

  cmos_dvp_cap_if bus ();

  cmos_dvp_cap #(.SKIP_FRAMES(2), .VS_POL(1), .CNT_W(12)) dut (
    .cmos_pclk_i   (clk),
    .rst_i         (rst),
    .bus           (bus),
    .fmt_i         (fmt),
    .frame_start_o (frame_start),
    .err_o         (err)
`ifdef CMOS_CAP_STATS_EN
    ,
    .line_px_o     (line_px),
    .frame_lines_o (frame_lines)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          de_cnt = 0;
  int          fs_cnt = 0;
  logic [23:0] pix_q[$];
  int          pix_t[$];
  logic [7:0]  bq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.de_o) begin
      de_cnt++;
      pix_q.push_back(bus.rgb_o);
      pix_t.push_back(cyc);
    end
    if (frame_start) fs_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.cmos_href_i = 1'b0;
      bus.cmos_data_i = 8'h00;
    end
  endtask

  task automatic vs_pulse();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.cmos_vsync_i = 1'b1;
    end
    @(negedge clk);
    bus.cmos_vsync_i = 1'b0;
    idle(6);
  endtask

  // Sends the queued bytes as one line, then idles long enough to drain.
  task automatic send_line();
    while (bq.size() > 0) begin
      @(negedge clk);
      bus.cmos_href_i = 1'b1;
      bus.cmos_data_i = bq.pop_front();
    end
    idle(5);
  endtask

  task automatic frame_565(input int lines, input int px);
    vs_pulse();
    for (int l = 0; l < lines; l++) begin
      for (int p = 0; p < px; p++) begin
        bq.push_back(8'hF8);
        bq.push_back(8'h00);
      end
      send_line();
    end
  endtask

  initial begin
    bus.cmos_vsync_i = 1'b0;
    bus.cmos_href_i  = 1'b0;
    bus.cmos_data_i  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_vs", bus.vs_o, 0);
    chk("rst_hs_de", {bus.hs_o, bus.de_o}, 0);
    chk("rst_rgb", bus.rgb_o, 0);
    chk("rst_fs_err", {frame_start, err}, 0);
    rst = 1'b0;

    frame_565(4, 8);
    frame_565(4, 8);
    chk("skip_de_cnt", de_cnt, 0);
    chk("skip_fs_cnt", fs_cnt, 0);

    frame_565(4, 8);
    chk("f3_de_cnt", de_cnt, 32);
    chk("f3_fs_cnt", fs_cnt, 1);
    chk("f3_err", err, 0);
    chk("f3_spacing", pix_t[1] - pix_t[0], 2);
    chk("f3_last_px", pix_q[31], 24'hFF0000);

    vs_pulse();
`ifdef CMOS_CAP_STATS_EN
    chk("stats_frame_lines", frame_lines, 4);
`endif
    pix_q.delete();
    bq = '{8'hF8, 8'h00, 8'h07, 8'hE0, 8'h00, 8'h1F};
    send_line();
    chk("565_red", pix_q[0], 24'hFF0000);
    chk("565_green", pix_q[1], 24'h00FF00);
    chk("565_blue", pix_q[2], 24'h0000FF);
    chk("565_err_clean", err, 0);

    pix_q.delete();
    bq = '{8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'hF8};
    send_line();
    chk("short_px_cnt", pix_q.size(), 3);
    chk("short_err", err, 1);
`ifdef CMOS_CAP_STATS_EN
    chk("stats_line_px", line_px, 3);
`endif

    fmt = 2'd1;
    pix_q.delete();
    bq = '{8'h12, 8'h34, 8'h56, 8'h78};
    send_line();
    chk("midfmt_px_cnt", pix_q.size(), 2);
    chk("midfmt_565", pix_q[0], 24'h1045A5);
    chk("err_sticky", err, 1);

    vs_pulse();
    chk("fs_clears_err", err, 0);
    chk("fs_cnt_f5", fs_cnt, 3);
    @(negedge clk); bus.cmos_href_i = 1'b1; bus.cmos_data_i = 8'h12;
    @(negedge clk); bus.cmos_data_i = 8'h34;
    @(negedge clk); bus.cmos_data_i = 8'h56;
    @(negedge clk); bus.cmos_href_i = 1'b0; bus.cmos_data_i = 8'h00;
    chk("888_lat1_de", bus.de_o, 0);
    @(negedge clk);
    chk("888_lat2_de", bus.de_o, 1);
    chk("888_rgb", bus.rgb_o, 24'h123456);
    idle(4);

    fmt = 2'd2;
    vs_pulse();
    pix_q.delete();
    bq = '{8'h80};
    send_line();
    chk("gray_rgb", pix_q[0], 24'h808080);

    fmt = 2'd3;
    vs_pulse();
    pix_q.delete();
    bq = '{8'h5A, 8'hA5};
    send_line();
    chk("rsvd_px_cnt", pix_q.size(), 2);
    chk("rsvd_rgb", pix_q[0], 24'h5A5A5A);

    @(negedge clk); bus.cmos_href_i = 1'b1; bus.cmos_data_i = 8'h11;
    @(negedge clk); bus.cmos_data_i = 8'h22;
    @(negedge clk); bus.cmos_data_i = 8'h33;
    chk("pre_rst_hs", bus.hs_o, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_hs_de", {bus.hs_o, bus.de_o}, 0);
    chk("async_rst_rgb", bus.rgb_o, 0);
`ifdef CMOS_CAP_STATS_EN
    chk("async_rst_stats", {line_px, frame_lines}, 0);
`endif
    idle(2);
    rst = 1'b0;
    fmt = 2'd0;
    de_cnt = 0;
    fs_cnt = 0;
    frame_565(1, 2);
    frame_565(1, 2);
    chk("rerun_skip_de", de_cnt, 0);
    frame_565(1, 2);
    chk("rerun_de_cnt", de_cnt, 2);
    chk("rerun_fs_cnt", fs_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
